alwr_demux_axis: RTL and testbench
==================================

# alwr_demux_axis

Write-side companion of the address-lite readback mux: accepts address-lite write transactions (address, data, strobe, ID), decodes the word address to one of `ADDR_TOTAL` register sinks and presents the write on that sink's AXI-S style valid/ready port. After the sink accepts, it returns a write response carrying the ID. Writes to addresses at or above `ADDR_TOTAL` are dropped and answered with an error flag. It sits between the control-bus bridge and the per-core configuration registers, parallel to the readback mux.

## Interface
Parameters:
- `DATA_BITS`, 2, log2 of bytes per word
- `DATA_WIDTH`, `8<<DATA_BITS`, word width
- `ADDR_TOTAL`, 16, number of sink ports
- `ADDR_WIDTH`, `$clog2(ADDR_TOTAL)+DATA_BITS`, byte address width
- `ID_WIDTH`, 1, transaction ID width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_al_awaddr`  in  `[ADDR_WIDTH-1:DATA_BITS]`  word address
- `s_al_awvalid` / `s_al_awready`  in/out  1  address handshake
- `s_al_awid`  in  `ID_WIDTH`  transaction ID
- `s_al_wdata`  in  `DATA_WIDTH`  write data
- `s_al_wstrb`  in  `DATA_WIDTH/8`  byte enables
- `s_al_wvalid` / `s_al_wready`  in/out  1  data handshake
- `s_al_bvalid` / `s_al_bready`  out/in  1  response handshake
- `s_al_bid`  out  `ID_WIDTH`  ID of completed write
- `s_al_berr`  out  1  1 = address out of range, write dropped
- `sn_wr_valid`  out  `ADDR_TOTAL`  one-hot sink write strobe
- `sn_wr_ready`  in  `ADDR_TOTAL`  per-sink accept
- `sn_wr_data`  out  `DATA_WIDTH`  shared data bus to all sinks
- `sn_wr_strb`  out  `DATA_WIDTH/8`  shared byte enables

## Operation
- Two registered slots: command slot (`cmd_v`, addr, id, data, strb) and response slot (`b_v`, id, err).
- Accept: `s_al_awready = s_al_wready = ~cmd_v & ~b_v & s_al_awvalid & s_al_wvalid`. AW and W are always accepted together in the same cycle. A lone AW or a lone W waits and is never half-consumed.
- Dispatch, valid address (`addr < ADDR_TOTAL`): `sn_wr_valid = cmd_v ? 1<<addr : 0`.
  - `sn_wr_data` and `sn_wr_strb` come from the command slot.
  - The strobe is held until `sn_wr_ready[addr]`. `sn_wr_ready` of non-selected sinks is ignored.
  - On handshake: `cmd_v<=0`, `b_v<=1`, `berr<=0`, `bid<=id`.
- Dispatch, invalid address: no `sn_wr_valid` bit is raised. In the first cycle with `cmd_v`, the slot moves to the response with `berr=1`.
- Response: `s_al_bvalid=b_v`. On `bvalid & bready`, `b_v<=0`. `bid`/`berr` are stable while `bvalid`.
- Because acceptance requires both slots empty, at most one write is in flight. Writes reach sinks in acceptance order.
- While no command is held, `sn_wr_data`/`sn_wr_strb` are don't-care; the implementation holds the last value.
- Width: the address compare uses the full `[ADDR_WIDTH-1:DATA_BITS]` field, so aliasing above `ADDR_TOTAL` is not permitted.

## Timing
- Reset values: `s_al_awready=0`, `s_al_wready=0`, `s_al_bvalid=0`, `s_al_bid=0`, `s_al_berr=0`, `sn_wr_valid=0`, `sn_wr_data=0`, `sn_wr_strb=0`.
- Accept at cycle T → `sn_wr_valid` at T+1.
- Sink ready at T+1 → `bvalid` at T+2.
- `bready` at T+2 → next accept possible at T+3. Peak throughput is 1 write per 3 cycles.
- Sink stall of k cycles adds k cycles. `bready` low holds `bvalid` and blocks new accepts.
- Invalid address: accept T → `bvalid`, `berr=1` at T+2, with no sink strobe in between.
- Reset mid-operation, including while `sn_wr_valid` is held: both slots clear next cycle and the write is lost. Sinks must tolerate valid dropping on reset.
- No combinational path from `sn_wr_ready` or `s_al_bready` to any `s_al_*ready` output.

## Structure
- Shared bus package: response encoding constants (`BERR_OK=0`, `BERR_DECODE=1`) shared with the readback mux invalid-data constant.
- Optional sub-module: reuse `axis_opt_pipeline` (PIPELINE=1, REG_READY=0) as the response slot. The command slot and decode stay in this module (~150 lines).

## Test plan
- Single write: addr 3, data 0xDEADBEEF, strb 0xF, id 1, sink always ready → `sn_wr_valid=0x0008` for exactly 1 cycle with that data; `bvalid` 2 cycles after accept, `bid=1`, `berr=0`.
- AW/W skew: AW valid 4 cycles before W → no ready until both are valid, then both readies rise in the same cycle; exactly one sink write.
- Sink backpressure: addr 15, `sn_wr_ready[15]` low 5 cycles → `sn_wr_valid[15]` and data stable 6 cycles; `bvalid` the cycle after the handshake.
- Invalid address 16 (ADDR_TOTAL=16), id 0 → `sn_wr_valid` stays 0; `bvalid` at T+2 with `berr=1`, `bid=0`.
- Response backpressure: `bready` low 10 cycles with a second write pending → `awready`/`wready` stay 0 until `bready`; the second write reaches its sink in order.
- Reset while `sn_wr_valid[2]` is held → all outputs 0 next cycle; a fresh write after reset completes normally.

Source files
------------

// File: rtl/alwr_demux_axis_pkg.sv
// Shared control-bus definitions for the address-lite write demux and its
// readback companion: write-response error encoding and a small helper.
package alwr_demux_axis_pkg;

   // Write response error flag encoding
   localparam logic BERR_OK     = 1'b0;  // write delivered to its sink
   localparam logic BERR_DECODE = 1'b1;  // address out of range, write dropped

   // Map an address-decode result onto the response error flag
   function automatic logic berr_encode(input logic addr_in_range);
      return addr_in_range ? BERR_OK : BERR_DECODE;
   endfunction

endpackage

// File: rtl/alwr_demux_axis.sv
// Address-lite write demux: takes one AW+W pair at a time, steers it onto the
// selected sink's valid/ready port, then answers with a write response.
// Out-of-range addresses never strobe a sink and are answered with BERR_DECODE.
module alwr_demux_axis
   import alwr_demux_axis_pkg::*;
#(
   parameter int DATA_BITS  = 2,
   parameter int DATA_WIDTH = 8 << DATA_BITS,
   parameter int ADDR_TOTAL = 16,
   parameter int ADDR_WIDTH = $clog2(ADDR_TOTAL) + DATA_BITS,
   parameter int ID_WIDTH   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   // address-lite write slave
   input  logic [ADDR_WIDTH-1:DATA_BITS]  s_al_awaddr,
   input  logic                           s_al_awvalid,
   output logic                           s_al_awready,
   input  logic [ID_WIDTH-1:0]            s_al_awid,
   input  logic [DATA_WIDTH-1:0]          s_al_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_al_wstrb,
   input  logic                           s_al_wvalid,
   output logic                           s_al_wready,
   output logic                           s_al_bvalid,
   input  logic                           s_al_bready,
   output logic [ID_WIDTH-1:0]            s_al_bid,
   output logic                           s_al_berr,
   // register sinks
   output logic [ADDR_TOTAL-1:0]          sn_wr_valid,
   input  logic [ADDR_TOTAL-1:0]          sn_wr_ready,
   output logic [DATA_WIDTH-1:0]          sn_wr_data,
   output logic [DATA_WIDTH/8-1:0]        sn_wr_strb
);

   localparam int WORD_W = ADDR_WIDTH - DATA_BITS;
   // One extra bit so ADDR_TOTAL itself is representable in the compare
   localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W + 1)'(ADDR_TOTAL);

   // command slot
   logic                           cmd_v_q,  cmd_v_d;
   logic [ADDR_WIDTH-1:DATA_BITS]  addr_q,   addr_d;
   logic [ID_WIDTH-1:0]            id_q,     id_d;
   logic [DATA_WIDTH-1:0]          data_q,   data_d;
   logic [DATA_WIDTH/8-1:0]        strb_q,   strb_d;
   // response slot
   logic                           b_v_q,    b_v_d;
   logic [ID_WIDTH-1:0]            bid_q,    bid_d;
   logic                           berr_q,   berr_d;

   logic accept;
   logic addr_ok;
   logic sink_hit;
   logic cmd_done;

   // Full-field range check: addresses past ADDR_TOTAL never alias onto a sink
   assign addr_ok = ({1'b0, addr_q} < ADDR_LIMIT);

   // Both slots must be empty, so only one write is ever in flight and AW/W
   // are consumed together; no path from sn_wr_ready or s_al_bready.
   assign accept       = ~rst & ~cmd_v_q & ~b_v_q & s_al_awvalid & s_al_wvalid;
   assign s_al_awready = accept;
   assign s_al_wready  = accept;

   // One-hot sink strobe decoded from the held command
   always_comb begin
      sn_wr_valid = '0;
      for (int i = 0; i < ADDR_TOTAL; i++) begin
         sn_wr_valid[i] = cmd_v_q & addr_ok & (addr_q == WORD_W'(i));
      end
   end

   // Only the selected sink's ready can complete the command
   assign sink_hit = |(sn_wr_valid & sn_wr_ready);
   assign cmd_done = cmd_v_q & (~addr_ok | sink_hit);

   // Next-state for both slots: accept, dispatch/drop, response handshake
   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a value unassigned,
      // which would otherwise infer a latch.
      cmd_v_d = cmd_v_q;
      addr_d  = addr_q;
      id_d    = id_q;
      data_d  = data_q;
      strb_d  = strb_q;
      b_v_d   = b_v_q;
      bid_d   = bid_q;
      berr_d  = berr_q;

      if (b_v_q && s_al_bready) begin
         b_v_d = 1'b0;
      end
      if (cmd_done) begin
         cmd_v_d = 1'b0;
         b_v_d   = 1'b1;
         bid_d   = id_q;
         berr_d  = berr_encode(addr_ok);
      end
      if (accept) begin
         cmd_v_d = 1'b1;
         addr_d  = s_al_awaddr;
         id_d    = s_al_awid;
         data_d  = s_al_wdata;
         strb_d  = s_al_wstrb;
      end
   end

   // Slot registers; synchronous reset drops any in-flight write
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of every other flop.
      if (rst) begin
         cmd_v_q <= 1'b0;
         addr_q  <= '0;
         id_q    <= '0;
         // NOTE: the payload registers are reset too because they drive the
         // sink data bus directly and must read as zero after reset.
         data_q  <= '0;
         strb_q  <= '0;
         b_v_q   <= 1'b0;
         bid_q   <= '0;
         berr_q  <= BERR_OK;
      end else begin
         cmd_v_q <= cmd_v_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         b_v_q   <= b_v_d;
         bid_q   <= bid_d;
         berr_q  <= berr_d;
      end
   end

   assign sn_wr_data  = data_q;
   assign sn_wr_strb  = strb_q;
   assign s_al_bvalid = b_v_q;
   assign s_al_bid    = bid_q;
   assign s_al_berr   = berr_q;

endmodule

// File: tb/tb_alwr_demux_axis.sv
// Self-checking bench for alwr_demux_axis: a transaction-level model of the
// single write in flight is compared against the DUT every cycle, and directed
// scenarios pin literal timing and values.
module tb_alwr_demux_axis;

   localparam int DB = 2;
   localparam int DW = 8 << DB;
   localparam int AT = 16;
   // Address field one bit wider than the decode needs, so word 16 is reachable
   localparam int AW = $clog2(AT) + DB + 1;
   localparam int IW = 1;
   localparam int SW = DW / 8;
   localparam int WA = AW - DB;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [AW-1:DB]   s_al_awaddr = '0;
   logic             s_al_awvalid = 1'b0;
   logic             s_al_awready;
   logic [IW-1:0]    s_al_awid = '0;
   logic [DW-1:0]    s_al_wdata = '0;
   logic [SW-1:0]    s_al_wstrb = '0;
   logic             s_al_wvalid = 1'b0;
   logic             s_al_wready;
   logic             s_al_bvalid;
   logic             s_al_bready = 1'b1;
   logic [IW-1:0]    s_al_bid;
   logic             s_al_berr;
   logic [AT-1:0]    sn_wr_valid;
   logic [AT-1:0]    sn_wr_ready = '1;
   logic [DW-1:0]    sn_wr_data;
   logic [SW-1:0]    sn_wr_strb;

   always #5 clk = ~clk;

   alwr_demux_axis #(
      .DATA_BITS (DB),
      .DATA_WIDTH(DW),
      .ADDR_TOTAL(AT),
      .ADDR_WIDTH(AW),
      .ID_WIDTH  (IW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_al_awaddr (s_al_awaddr),
      .s_al_awvalid(s_al_awvalid),
      .s_al_awready(s_al_awready),
      .s_al_awid   (s_al_awid),
      .s_al_wdata  (s_al_wdata),
      .s_al_wstrb  (s_al_wstrb),
      .s_al_wvalid (s_al_wvalid),
      .s_al_wready (s_al_wready),
      .s_al_bvalid (s_al_bvalid),
      .s_al_bready (s_al_bready),
      .s_al_bid    (s_al_bid),
      .s_al_berr   (s_al_berr),
      .sn_wr_valid (sn_wr_valid),
      .sn_wr_ready (sn_wr_ready),
      .sn_wr_data  (sn_wr_data),
      .sn_wr_strb  (sn_wr_strb)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The write in flight is either idle, waiting at its sink, or waiting for
   // its response to be taken.
   typedef enum int {IDLE, AT_SINK, ANSWER} phase_e;
   phase_e          phase = IDLE;
   logic [WA-1:0]   m_addr = '0;
   logic [DW-1:0]   m_data = '0;
   logic [SW-1:0]   m_strb = '0;
   logic [IW-1:0]   m_id = '0;
   int              m_sink_cnt = 0;
   int              dut_sink_q[$];
   bit              chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         phase = IDLE;
      end else begin
         case (phase)
            IDLE: if (s_al_awvalid && s_al_wvalid) begin
               m_addr = s_al_awaddr;
               m_data = s_al_wdata;
               m_strb = s_al_wstrb;
               m_id   = s_al_awid;
               phase  = AT_SINK;
            end
            AT_SINK: begin
               if (int'(m_addr) >= AT) begin
                  phase = ANSWER;
               end else if (sn_wr_ready[int'(m_addr)]) begin
                  phase = ANSWER;
                  m_sink_cnt++;
               end
            end
            default: if (s_al_bready) phase = IDLE;
         endcase
      end
   end

   // Compare process plus a log of sink handshakes as the DUT performs them
   always @(negedge clk) begin : compare
      logic [AT-1:0] exp_snv;
      if (!rst && (sn_wr_valid & sn_wr_ready) != '0) begin
         for (int i = 0; i < AT; i++) begin
            if (sn_wr_valid[i] && sn_wr_ready[i]) dut_sink_q.push_back(i);
         end
      end
      if (chk_en) begin
         exp_snv = '0;
         if (phase == AT_SINK && int'(m_addr) < AT) exp_snv[int'(m_addr)] = 1'b1;
         check("m_awready", s_al_awready, !rst && phase == IDLE && s_al_awvalid && s_al_wvalid);
         check("m_wready", s_al_wready, !rst && phase == IDLE && s_al_awvalid && s_al_wvalid);
         check("m_sn_wr_valid", sn_wr_valid, exp_snv);
         check("m_bvalid", s_al_bvalid, phase == ANSWER);
         if (phase == AT_SINK) begin
            check("m_sn_wr_data", sn_wr_data, m_data);
            check("m_sn_wr_strb", sn_wr_strb, m_strb);
         end
         if (phase == ANSWER) begin
            check("m_bid", s_al_bid, m_id);
            check("m_berr", s_al_berr, int'(m_addr) >= AT);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_aw(input int a, input logic [IW-1:0] id);
      s_al_awaddr  = WA'(a);
      s_al_awid    = id;
      s_al_awvalid = 1'b1;
   endtask

   task automatic set_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
      s_al_wdata  = d;
      s_al_wstrb  = s;
      s_al_wvalid = 1'b1;
   endtask

   // Hold AW/W until taken, then release them just after the accepting edge
   task automatic wait_accept(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (s_al_awready) ok = 1'b1;
         step();
      end
      s_al_awvalid = 1'b0;
      s_al_wvalid  = 1'b0;
      check(name, ok, 1'b1);
   endtask

   // Return at the first negedge with bvalid high
   task automatic wait_bvalid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (s_al_bvalid) ok = 1'b1;
         else step();
      end
      check(name, ok, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_awready"}, s_al_awready, 0);
      check({tag, "_wready"}, s_al_wready, 0);
      check({tag, "_bvalid"}, s_al_bvalid, 0);
      check({tag, "_bid"}, s_al_bid, 0);
      check({tag, "_berr"}, s_al_berr, 0);
      check({tag, "_sn_wr_valid"}, sn_wr_valid, 0);
      check({tag, "_sn_wr_data"}, sn_wr_data, 0);
      check({tag, "_sn_wr_strb"}, sn_wr_strb, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cnt0;

      // ---- reset ----
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // ---- single write: strobe for one cycle, response two cycles after accept ----
      step();
      set_aw(3, 1'b1);
      set_w(32'hDEADBEEF, 4'hF);
      @(negedge clk);
      check("t1_awready", s_al_awready, 1);
      check("t1_wready", s_al_wready, 1);
      step();
      s_al_awvalid = 1'b0;
      s_al_wvalid  = 1'b0;
      @(negedge clk);
      check("t1_sn_wr_valid", sn_wr_valid, 16'h0008);
      check("t1_sn_wr_data", sn_wr_data, 32'hDEADBEEF);
      check("t1_sn_wr_strb", sn_wr_strb, 4'hF);
      check("t1_bvalid_early", s_al_bvalid, 0);
      step();
      @(negedge clk);
      check("t1_sn_wr_valid_drop", sn_wr_valid, 0);
      check("t1_bvalid", s_al_bvalid, 1);
      check("t1_bid", s_al_bid, 1);
      check("t1_berr", s_al_berr, 0);
      step();
      @(negedge clk);
      check("t1_bvalid_clear", s_al_bvalid, 0);

      // ---- AW leads W by 4 cycles ----
      step();
      cnt0 = dut_sink_q.size();
      set_aw(5, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_awready_wait", s_al_awready, 0);
         check("t2_wready_wait", s_al_wready, 0);
         step();
      end
      set_w(32'h12345678, 4'h3);
      @(negedge clk);
      check("t2_awready", s_al_awready, 1);
      check("t2_wready", s_al_wready, 1);
      step();
      s_al_awvalid = 1'b0;
      s_al_wvalid  = 1'b0;
      wait_bvalid("t2_bvalid_timeout");
      check("t2_sink_writes", dut_sink_q.size(), cnt0 + 1);
      check("t2_sink_addr", dut_sink_q[$], 5);
      step();

      // ---- sink backpressure on word 15; other sinks ready but ignored ----
      sn_wr_ready = 16'h7FFF;
      set_aw(15, 1'b1);
      set_w(32'hCAFE0015, 4'hA);
      wait_accept("t3_accept_timeout");
      for (int k = 0; k < 6; k++) begin
         if (k == 5) sn_wr_ready[15] = 1'b1;
         @(negedge clk);
         check("t3_sn_wr_valid_held", sn_wr_valid, 16'h8000);
         check("t3_sn_wr_data_held", sn_wr_data, 32'hCAFE0015);
         step();
      end
      @(negedge clk);
      check("t3_bvalid", s_al_bvalid, 1);
      check("t3_sn_wr_valid_drop", sn_wr_valid, 0);
      check("t3_bid", s_al_bid, 1);
      step();

      // ---- out-of-range word 16 ----
      cnt0 = dut_sink_q.size();
      set_aw(16, 1'b0);
      set_w(32'hBAD0BAD0, 4'hF);
      @(negedge clk);
      check("t4_awready", s_al_awready, 1);
      step();
      s_al_awvalid = 1'b0;
      s_al_wvalid  = 1'b0;
      @(negedge clk);
      check("t4_sn_wr_valid_t1", sn_wr_valid, 0);
      check("t4_bvalid_t1", s_al_bvalid, 0);
      step();
      @(negedge clk);
      check("t4_sn_wr_valid_t2", sn_wr_valid, 0);
      check("t4_bvalid", s_al_bvalid, 1);
      check("t4_berr", s_al_berr, 1);
      check("t4_bid", s_al_bid, 0);
      check("t4_no_sink_write", dut_sink_q.size(), cnt0);
      step();

      // ---- response backpressure with a second write waiting ----
      s_al_bready = 1'b0;
      set_aw(7, 1'b0);
      set_w(32'h00000707, 4'hF);
      wait_accept("t5_accept_a_timeout");
      set_aw(9, 1'b1);
      set_w(32'h00000909, 4'hC);
      wait_bvalid("t5_bvalid_a_timeout");
      step();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t5_awready_blocked", s_al_awready, 0);
         check("t5_wready_blocked", s_al_wready, 0);
         step();
      end
      s_al_bready = 1'b1;
      @(negedge clk);
      check("t5_awready_bhs", s_al_awready, 0);
      check("t5_bid_a", s_al_bid, 0);
      step();
      @(negedge clk);
      check("t5_awready_b", s_al_awready, 1);
      step();
      s_al_awvalid = 1'b0;
      s_al_wvalid  = 1'b0;
      wait_bvalid("t5_bvalid_b_timeout");
      check("t5_bid_b", s_al_bid, 1);
      check("t5_berr_b", s_al_berr, 0);
      check("t5_order_first", dut_sink_q[dut_sink_q.size() - 2], 7);
      check("t5_order_second", dut_sink_q[dut_sink_q.size() - 1], 9);
      step();

      // ---- reset while sink 2 is stalled ----
      sn_wr_ready = 16'hFFFB;
      set_aw(2, 1'b0);
      set_w(32'h22222222, 4'hF);
      wait_accept("t6_accept_timeout");
      @(negedge clk);
      check("t6_sn_wr_valid_held", sn_wr_valid, 16'h0004);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("t6_after_reset");
      sn_wr_ready = '1;
      step();
      set_aw(2, 1'b1);
      set_w(32'h600DF00D, 4'h5);
      wait_accept("t6_accept2_timeout");
      @(negedge clk);
      check("t6_sn_wr_valid", sn_wr_valid, 16'h0004);
      check("t6_sn_wr_data", sn_wr_data, 32'h600DF00D);
      check("t6_sn_wr_strb", sn_wr_strb, 4'h5);
      wait_bvalid("t6_bvalid_timeout");
      check("t6_bid", s_al_bid, 1);
      check("t6_berr", s_al_berr, 0);
      check("t6_sink_addr", dut_sink_q[$], 2);
      step();
      step();

      // ---- totals: words 3,5,15,7,9,2 reached sinks; the reset write was lost ----
      check("total_sink_writes", dut_sink_q.size(), 6);
      check("model_sink_writes", dut_sink_q.size(), m_sink_cnt);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
